// File: rtl/mem_lsu.sv
// Memory-access stage: launches loads/stores on a req/ack bus with byte-lane alignment and load extension.
// Latency: 3 cycles for a zero-wait access (IDLE, BUSY, DONE); stallreq holds upstream until DONE.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              flush,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              addr_err,
    output logic              stallreq,
    output logic              data_req,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_be,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_ack
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                is_load, is_store, is_mem;
    logic                sz_byte, sz_half, misaligned;
    logic [3:0]          be_c;
    logic [DATA_W-1:0]   wdata_c, lane_c, load_c;

    // Operation decode, lane selection and load extension
    always_comb begin
        is_load    = aluop_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_store   = aluop_i inside {OP_SB, OP_SH, OP_SW};
        is_mem     = is_load || is_store;
        sz_byte    = aluop_i inside {OP_LB, OP_LBU, OP_SB};
        sz_half    = aluop_i inside {OP_LH, OP_LHU, OP_SH};
        misaligned = (sz_half && mem_addr_i[0]) ||
                     (!sz_byte && !sz_half && is_mem && (mem_addr_i[1:0] != 2'b00));

        be_c    = 4'b1111;
        wdata_c = reg2_i;
        if (sz_byte) begin
            be_c    = 4'b0001 << mem_addr_i[1:0];
            wdata_c = {4{reg2_i[7:0]}};
        end else if (sz_half) begin
            be_c    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{reg2_i[15:0]}};
        end

        lane_c = data_rdata >> {mem_addr_i[1:0], 3'b000};
        case (aluop_i)
            OP_LB:   load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            OP_LBU:  load_c = {24'd0, lane_c[7:0]};
            OP_LH:   load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            OP_LHU:  load_c = {16'd0, lane_c[15:0]};
            default: load_c = data_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (is_mem && !misaligned && !flush) begin
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    be_d    = be_c;
                    wdat_d  = wdata_c;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (data_ack) begin
                    req_d   = 1'b0;
                    rdata_d = load_c;
                    state_d = flush ? IDLE : DONE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The bus cannot be abandoned, so wait out the ack and drop the data
                if (data_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wd_o     = '0;
        wreg_o   = 1'b0;
        wdata_o  = '0;
        addr_err = 1'b0;
        stallreq = 1'b0;
        if (!rst) begin
            wd_o     = wd_i;
            wreg_o   = wreg_i && !flush && (!is_mem || (is_load && state_q == DONE));
            wdata_o  = (is_load && state_q == DONE) ? rdata_q : wdata_i;
            addr_err = is_mem && misaligned && !flush;
            stallreq = is_mem && (state_q != DONE) && !flush && !misaligned;
        end
    end

    assign data_req   = req_q;
    assign data_we    = we_q;
    assign data_addr  = addr_q;
    assign data_be    = be_q;
    assign data_wdata = wdat_q;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage MIPS pipeline.
- Consumes the execute stage's aluop, memory address, store operand (reg2) and write-back fields.
- Performs loads and stores over a req/ack data-bus handshake, with byte-lane alignment and sign/zero extension.
- Holds the pipeline through stallreq until the access completes. Non-memory ops pass straight through to write-back.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, register/data width; fixed at 32 (byte lanes assume 4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- aluop_i  in  8  operation code from execute stage
- wd_i  in  5  destination register number
- wreg_i  in  1  destination write enable
- wdata_i  in  32  execute-stage result (non-memory ops)
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- flush  in  1  squash current instruction
- wd_o  out  5  destination register to write-back
- wreg_o  out  1  write enable to write-back
- wdata_o  out  32  write-back data
- addr_err  out  1  misaligned access flag (1 cycle)
- stallreq  out  1  pipeline stall request
- data_req  out  1  bus request
- data_we  out  1  bus write
- data_addr  out  32  word-aligned bus address (addr[1:0]=0)
- data_be  out  4  byte enables
- data_wdata  out  32  bus write data
- data_rdata  in  32  bus read data
- data_ack  in  1  bus completion, single cycle

Behaviour:
- Op codes:
  - LB=0xE0, LH=0xE1, LW=0xE3, LBU=0xE4, LHU=0xE5
  - SB=0xE8, SH=0xE9, SW=0xEB
  - Any other code is non-memory.
- Byte ordering: little-endian; byte lane k = mem_addr_i[1:0]==k, be[k] set.
- Non-memory op:
  - wd_o/wreg_o/wdata_o = inputs, combinationally.
  - stallreq=0, no bus activity.
- Alignment:
  - H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned access: no bus request, addr_err=1 for that cycle, wreg_o=0, stallreq=0.
- FSM states: IDLE, BUSY, DONE, DRAIN.
  - IDLE + valid aligned mem op + !flush:
    - Register data_req=1, data_we, data_addr, data_be.
    - data_wdata = store data replicated into the lane (SB: {4{b}}, SH: {2{h}}).
    - Next state BUSY.
  - BUSY: hold all bus outputs stable until data_ack=1. On ack:
    - data_req=0.
    - Capture the lane-selected, extended load value in rdata_q.
    - Next state DONE.
  - DONE:
    - stallreq=0; loads drive wdata_o=rdata_q with wreg_o=wreg_i; stores drive wreg_o=0.
    - Next state IDLE.
  - flush while in BUSY: next state DRAIN. DRAIN keeps req high until ack, discards data, then goes to IDLE. stallreq=0 in DRAIN; an upstream op arriving is held in IDLE-entry until DRAIN exits (stallreq=1 for it).
  - flush in IDLE/DONE: outputs wreg_o=0, no request launched.
- stallreq = mem op present && state != DONE && !flush && !misaligned, combinational.
- wreg_o=0 whenever a memory op has not reached DONE.
- Latency: ack on first BUSY cycle gives 3 cycles (IDLE, BUSY, DONE). Each extra wait cycle adds one.
- Upstream holds inputs constant while stallreq=1.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW is the raw word.
- Reset (async, any state):
  - state=IDLE; data_req=0, data_we=0, data_addr=0, data_be=0, data_wdata=0, rdata_q=0.
  - While rst=1: wd_o=0, wreg_o=0, wdata_o=0, addr_err=0, stallreq=0.
  - A bus transaction in flight is abandoned. The bus slave is reset by the same rst.
- data_ack outside BUSY/DRAIN is ignored.

Test Plan:
- ADD result: aluop 0x21, wdata_i=0x1234, wreg_i=1, wd_i=3 -> same cycle wdata_o=0x1234, wreg_o=1, wd_o=3, stallreq=0, data_req=0.
- LB, addr 0x1003, rdata 0x80FF_0000, ack on first BUSY cycle:
  - be=4'b1000, data_addr=0x1000.
  - stallreq high 2 cycles; DONE gives wdata_o=0xFFFF_FF80, wreg_o=1.
- LHU, addr 0x2002, rdata 0x8001_1111, ack after 3 wait cycles -> stallreq 5 cycles, wdata_o=0x0000_8001.
- SB, addr 0x3001, reg2=0xAABB_CCDD -> data_we=1, be=4'b0010, data_wdata=0xDDDD_DDDD; DONE has wreg_o=0.
- SW, addr 0x4002 -> addr_err=1 one cycle, no data_req, stallreq=0, wreg_o=0.
- LW in BUSY, flush=1 for one cycle, ack 2 cycles later -> data_req held until ack, wreg_o never 1, state IDLE after ack.
- Assert rst mid-BUSY -> data_req=0 immediately (async), all outputs 0; after release a new LW completes normally.
